modulo_coord_cursor: RTL and testbench
======================================

// Module: modulo_coord_cursor
// PURPOSE
//   Sequential, parametrised successor to the combinational column-coordinate encoder.
//   Holds a (column,row) cursor over an N_COL x N_ROW board and steps it on button presses.
//   Wraps the cursor at the board edges and encodes each index as a display digit.
//   Presents the confirmed coordinate to the game logic with a valid/ack handshake.
// PARAMETERS
//   N_COL    5  number of columns, 2..2**W_COORD
//   N_ROW    5  number of rows, 2..2**W_COORD
//   W_COORD  3  index width in bits
//   DIG_W    4  display digit width in bits; must be >= W_COORD
// PORTS
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   en         in   1        1 = cursor editing enabled
//   btn_col    in   1        column-step button, level, active-high, already debounced
//   btn_row    in   1        row-step button, level, active-high, already debounced
//   dir        in   1        step direction: 0 = +1, 1 = -1
//   btn_ok     in   1        confirm button, level, active-high
//   sel_ack    in   1        consumer accepts the confirmed coordinate
//   col_idx    out  W_COORD  current column index
//   row_idx    out  W_COORD  current row index
//   cdc        out  DIG_W    column digit, col_idx zero-extended (MSBs 0)
//   rdc        out  DIG_W    row digit, row_idx zero-extended
//   sel_valid  out  1        confirmed coordinate pending
//   busy       out  1        1 while the FSM is in S_WAIT
// BEHAVIOUR
//   - Reset (async assert, sync release): col_idx=0, row_idx=0, cdc=0, rdc=0,
//     sel_valid=0, busy=0, FSM=S_IDLE, edge-detector history=0.
//   - Edge detect: each button is registered. A press is the rising edge (prev=0, cur=1).
//     One press produces exactly one action, however long the button is held.
//   - FSM:
//     - S_IDLE: presses are ignored. en=1 -> S_EDIT on the next cycle.
//     - S_EDIT: en=0 -> S_IDLE; the index is held.
//       - Column press: col_idx steps by +/-1 per dir.
//       - Row press: row_idx steps by +/-1 per dir.
//       - Column and row presses in the same cycle: both indices step.
//       - ok press: go to S_WAIT and set sel_valid=1 on the next edge. Any column/row
//         press in that same cycle is discarded (ok wins).
//     - S_WAIT: sel_valid=1 and busy=1; indices frozen; all presses ignored; en ignored.
//       sel_ack=1 -> sel_valid=0, then S_EDIT if en=1, else S_IDLE.
//       Ack in the same cycle valid first rises is not possible (valid is registered).
//   - Wrap-around:
//     - +1 from N_COL-1 -> 0; -1 from 0 -> N_COL-1. Rows wrap the same way with N_ROW.
//     - Index arithmetic is W_COORD bits. An index never reaches >= N_COL/N_ROW.
//   - Latency: 1 clk from the press edge (as sampled) to the index update.
//     cdc/rdc are registered alongside the indices, so they change in the same cycle.
//   - sel_ack while not in S_WAIT: ignored.
//   - Reset mid-handshake: sel_valid drops immediately (async). The consumer must discard.
// STRUCTURE
//   - Shared package coord_pkg: state encoding S_IDLE=2'd0, S_EDIT=2'd1, S_WAIT=2'd2;
//     W_COORD/DIG_W defaults; wrap-increment/decrement function.
//   - Sub-module detector_borda (clk, rst_n, d, pulse): 1-cycle rising-edge pulse.
//     Instanced 3x (btn_col, btn_row, btn_ok).
//   - The top holds the FSM, the index counters and the digit registers.
// TESTING
//   1. Reset: rst_n=0 mid-cycle -> all outputs 0 at once; release, en=1 -> S_EDIT next clk.
//   2. Hold btn_col high 10 cycles, dir=0 -> col_idx 0->1 exactly once, cdc=4'b0001.
//   3. dir=0, 5 column presses (N_COL=5) -> col_idx 1,2,3,4,0.
//      dir=1 from 0 -> 4. Same check for rows.
//   4. btn_col, btn_row and btn_ok rise in the same cycle at (2,3) ->
//      indices stay (2,3), sel_valid=1 next clk.
//   5. In S_WAIT, presses and en=0 -> indices frozen.
//      sel_ack=1 -> sel_valid=0; with en=0 -> S_IDLE.
//   6. Assert rst_n=0 while sel_valid=1 -> sel_valid=0 and (0,0) at once.
//      Re-run with N_COL=8, N_ROW=3.

Source files
------------

// File: rtl/coord_pkg.sv
// coord_pkg: shared state encoding, default widths and wrap-around stepping for the coordinate cursor
package coord_pkg;
  localparam int DEF_W_COORD = 3;
  localparam int DEF_DIG_W = 4;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EDIT = 2'd1,
    S_WAIT = 2'd2
  } state_t;
  function automatic int wrap_step(input int i, input int n, input logic dn);
    return dn ? ((i == 0) ? n - 1 : i - 1) : ((i == n - 1) ? 0 : i + 1);
  endfunction
endpackage

// File: rtl/detector_borda.sv
// detector_borda: one-cycle pulse on each rising edge of a level input
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else q <= d;
  assign pulse = d & ~q;
endmodule

// File: rtl/modulo_coord_cursor.sv
// modulo_coord_cursor: wrapping (column,row) cursor with digit outputs and a valid/ack confirm handshake
module modulo_coord_cursor
  import coord_pkg::*;
#(
  parameter int N_COL = 5,
  parameter int N_ROW = 5,
  parameter int W_COORD = DEF_W_COORD,
  parameter int DIG_W = DEF_DIG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               btn_col,
  input  logic               btn_row,
  input  logic               dir,
  input  logic               btn_ok,
  input  logic               sel_ack,
  output logic [W_COORD-1:0] col_idx,
  output logic [W_COORD-1:0] row_idx,
  output logic [DIG_W-1:0]   cdc,
  output logic [DIG_W-1:0]   rdc,
  output logic               sel_valid,
  output logic               busy
);
  state_t state, nxt;
  logic col_p, row_p, ok_p, step;
  logic [W_COORD-1:0] col_nxt, row_nxt;
  detector_borda u_col (.clk(clk), .rst_n(rst_n), .d(btn_col), .pulse(col_p));
  detector_borda u_row (.clk(clk), .rst_n(rst_n), .d(btn_row), .pulse(row_p));
  detector_borda u_ok  (.clk(clk), .rst_n(rst_n), .d(btn_ok),  .pulse(ok_p));
  // ok outranks any simultaneous column/row press, so a confirm never moves the cursor
  always_comb begin
    nxt = (state == S_IDLE) ? (en ? S_EDIT : S_IDLE) :
          (state == S_EDIT) ? (!en ? S_IDLE : (ok_p ? S_WAIT : S_EDIT)) :
          (state == S_WAIT) ? (sel_ack ? (en ? S_EDIT : S_IDLE) : S_WAIT) : S_IDLE;
    step = (state == S_EDIT) && en && !ok_p;
    col_nxt = (step && col_p) ? W_COORD'(wrap_step(int'(col_idx), N_COL, dir)) : col_idx;
    row_nxt = (step && row_p) ? W_COORD'(wrap_step(int'(row_idx), N_ROW, dir)) : row_idx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_IDLE;
      col_idx <= '0;
      row_idx <= '0;
      cdc     <= '0;
      rdc     <= '0;
    end else begin
      state   <= nxt;
      col_idx <= col_nxt;
      row_idx <= row_nxt;
      cdc     <= DIG_W'(col_nxt);
      rdc     <= DIG_W'(row_nxt);
    end
  assign sel_valid = (state == S_WAIT);
  assign busy = (state == S_WAIT);
endmodule

// File: tb/tb_modulo_coord_cursor.sv
// tb_modulo_coord_cursor: directed vector table over a 5x5 and an 8x3 cursor driven in lockstep
module tb_modulo_coord_cursor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, btn_col = 1'b0, btn_row = 1'b0, dir = 1'b0, btn_ok = 1'b0, sel_ack = 1'b0;
  logic [2:0] a_col, a_row, b_col, b_row;
  logic [3:0] a_cdc, a_rdc, b_cdc, b_rdc;
  logic a_valid, a_busy, b_valid, b_busy;
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  modulo_coord_cursor #(.N_COL(5), .N_ROW(5), .W_COORD(3), .DIG_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .btn_col(btn_col), .btn_row(btn_row), .dir(dir),
    .btn_ok(btn_ok), .sel_ack(sel_ack), .col_idx(a_col), .row_idx(a_row), .cdc(a_cdc),
    .rdc(a_rdc), .sel_valid(a_valid), .busy(a_busy));

  modulo_coord_cursor #(.N_COL(8), .N_ROW(3), .W_COORD(3), .DIG_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .btn_col(btn_col), .btn_row(btn_row), .dir(dir),
    .btn_ok(btn_ok), .sel_ack(sel_ack), .col_idx(b_col), .row_idx(b_row), .cdc(b_cdc),
    .rdc(b_rdc), .sel_valid(b_valid), .busy(b_busy));

  typedef struct {
    logic e, c, r, d, o, k;
    int ac, ar, xc, xr;
    logic v;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic e, c, r, d, o, k, input int ac, ar, xc, xr, input logic v);
    vec_t t;
    t = '{e, c, r, d, o, k, ac, ar, xc, xr, v};
    tv.push_back(t);
  endtask

  task automatic pr(input logic c, r, d, input int ac, ar, xc, xr);
    add(1'b1, c, r, d, 1'b0, 1'b0, ac, ar, xc, xr, 1'b0);
    add(1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0, ac, ar, xc, xr, 1'b0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input int ac, ar, xc, xr, input logic v);
    chk({tag, " a_col"}, int'(a_col), ac);
    chk({tag, " a_row"}, int'(a_row), ar);
    chk({tag, " a_cdc"}, int'(a_cdc), ac);
    chk({tag, " a_rdc"}, int'(a_rdc), ar);
    chk({tag, " a_valid"}, int'(a_valid), int'(v));
    chk({tag, " a_busy"}, int'(a_busy), int'(v));
    chk({tag, " b_col"}, int'(b_col), xc);
    chk({tag, " b_row"}, int'(b_row), xr);
    chk({tag, " b_cdc"}, int'(b_cdc), xc);
    chk({tag, " b_rdc"}, int'(b_rdc), xr);
    chk({tag, " b_valid"}, int'(b_valid), int'(v));
    chk({tag, " b_busy"}, int'(b_busy), int'(v));
  endtask

  task automatic drive(input logic e, c, r, d, o, k);
    en = e; btn_col = c; btn_row = r; dir = d; btn_ok = o; sel_ack = k;
  endtask

  initial begin
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    pr(1, 0, 0, 2, 0, 2, 0);
    pr(1, 0, 0, 3, 0, 3, 0);
    pr(1, 0, 0, 4, 0, 4, 0);
    pr(1, 0, 0, 0, 0, 5, 0);
    pr(1, 0, 1, 4, 0, 4, 0);
    pr(1, 0, 0, 0, 0, 5, 0);
    pr(1, 0, 0, 1, 0, 6, 0);
    pr(1, 0, 0, 2, 0, 7, 0);
    pr(0, 1, 1, 2, 4, 7, 2);
    pr(0, 1, 0, 2, 0, 7, 0);
    pr(0, 1, 0, 2, 1, 7, 1);
    pr(0, 1, 0, 2, 2, 7, 2);
    pr(0, 1, 0, 2, 3, 7, 0);
    pr(1, 1, 1, 1, 2, 6, 2);
    pr(1, 1, 0, 2, 3, 7, 0);
    add(1, 1, 1, 0, 1, 0, 2, 3, 7, 0, 1);
    add(1, 0, 0, 0, 0, 0, 2, 3, 7, 0, 1);
    add(0, 1, 1, 0, 0, 0, 2, 3, 7, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 3, 7, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2, 3, 7, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2, 3, 7, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 3, 7, 0, 0);
    add(1, 1, 0, 0, 0, 1, 3, 3, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 3, 3, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 3, 3, 0, 0, 1);
    add(1, 0, 0, 0, 1, 1, 3, 3, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 3, 3, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4, 3, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 4, 3, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 4, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 3, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 4, 3, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 4, 3, 1, 0, 1);

    #2;
    chk_all("reset", 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].e, tv[i].c, tv[i].r, tv[i].d, tv[i].o, tv[i].k);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), tv[i].ac, tv[i].ar, tv[i].xc, tv[i].xr, tv[i].v);
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid_wait", 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst_idle", 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    drive(1, 1, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_all("post_rst_edit", 4, 4, 7, 2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
